// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg
//   Shared pipeline definitions for the ID-stage operand bypass.
//   - FWD_* : forward-source encodings driven on fwd_rs_src / fwd_rt_src
//   - pipe_tag_t : destination tag {wen, waddr, is_load} carried per stage
//   - TAG_INVALID : the tag used for reset and for inserted bubbles
//   - tag_valid / tag_hits : helpers shared by every consumer of a tag
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef struct packed {
        logic                  wen;
        logic [REG_ADDR_W-1:0] waddr;
        logic                  is_load;
    } pipe_tag_t;

    localparam pipe_tag_t TAG_INVALID = '0;

    // A write to r0 is architecturally discarded, so such a tag never forwards.
    function automatic logic tag_valid(input pipe_tag_t t);
        return t.wen && (t.waddr != '0);
    endfunction

    function automatic logic tag_hits(input pipe_tag_t t, input logic [REG_ADDR_W-1:0] addr);
        return tag_valid(t) && (t.waddr == addr);
    endfunction

endpackage

// File: rtl/id_operand_bypass_stage_tag_reg.sv
// -----------------------------------------------------------------------------
// stage_tag_reg
//   One pipeline destination-tag register.
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low clear to TAG_INVALID
//     hold_i   in   keep the current tag (pipeline frozen)
//     bubble_i in   load TAG_INVALID instead of tag_i
//     tag_i    in   tag of the preceding stage
//     tag_o    out  registered tag of this stage
// -----------------------------------------------------------------------------
module stage_tag_reg
    import cpu_pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      hold_i,
    input  logic      bubble_i,
    input  pipe_tag_t tag_i,
    output pipe_tag_t tag_o
);

    pipe_tag_t tag_q;
    pipe_tag_t tag_d;

    always_comb begin
        tag_d = tag_q;
        if (!hold_i) begin
            tag_d = bubble_i ? TAG_INVALID : tag_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= TAG_INVALID;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_o = tag_q;

endmodule

// File: rtl/id_operand_bypass.sv
// -----------------------------------------------------------------------------
// id_operand_bypass
//   ID-stage operand bypass network. Tracks destination tags of the EXE, MEM
//   and WB instructions, forwards the youngest matching result over the
//   register-file read for rs and rt, and raises a load-use stall when a
//   needed value is still in flight inside a load.
//   Ports:
//     clk, rst_n               clock / asynchronous active-low reset
//     pipe_hold                global freeze; tags do not advance
//     id_flush                 squash the ID instruction
//     id_rs_addr/id_rt_addr    operand register indices
//     id_rs_used/id_rt_used    operand actually read by the instruction
//     id_wen/id_waddr/id_is_load  destination tag of the ID instruction
//     rf_rs_value/rf_rt_value  register-file read data
//     exe_result/mem_result/wb_result  in-flight results per stage
//     rs_value/rt_value        forwarded operands
//     fwd_rs_src/fwd_rt_src    00 rf, 01 exe, 10 mem, 11 wb
//     stall                    hold PC and IF/ID, bubble into ID/EXE
//     stall_count              saturating count of non-held stall cycles
//   ADDR_W must match cpu_pipe_pkg::REG_ADDR_W (the tag width).
// -----------------------------------------------------------------------------
module id_operand_bypass
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_hold,
    input  logic              id_flush,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wen,
    input  logic [ADDR_W-1:0] id_waddr,
    input  logic              id_is_load,
    input  logic [DATA_W-1:0] rf_rs_value,
    input  logic [DATA_W-1:0] rf_rt_value,
    input  logic [DATA_W-1:0] exe_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] rs_value,
    output logic [DATA_W-1:0] rt_value,
    output logic [1:0]        fwd_rs_src,
    output logic [1:0]        fwd_rt_src,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    pipe_tag_t id_tag;
    pipe_tag_t exe_tag_q;
    pipe_tag_t mem_tag_q;
    pipe_tag_t wb_tag_q;
    logic      exe_bubble;

    assign id_tag = '{wen: id_wen, waddr: id_waddr, is_load: id_is_load};

    // A stalled or squashed ID instruction must not enter EXE.
    assign exe_bubble = stall | id_flush;

    stage_tag_reg u_exe_tag (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (pipe_hold),
        .bubble_i (exe_bubble),
        .tag_i    (id_tag),
        .tag_o    (exe_tag_q)
    );

    stage_tag_reg u_mem_tag (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (pipe_hold),
        .bubble_i (1'b0),
        .tag_i    (exe_tag_q),
        .tag_o    (mem_tag_q)
    );

    stage_tag_reg u_wb_tag (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (pipe_hold),
        .bubble_i (1'b0),
        .tag_i    (mem_tag_q),
        .tag_o    (wb_tag_q)
    );

    // Operand 0 is rs, operand 1 is rt; both share the same select/hazard logic.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic [ADDR_W-1:0] addr;
            logic              used;
            logic [DATA_W-1:0] rf_value;
            logic [DATA_W-1:0] value;
            logic [1:0]        src;
            logic              exe_load_hit;
            logic              mem_load_hit;
            logic              hazard;

            assign addr     = (gi == 0) ? id_rs_addr  : id_rt_addr;
            assign used     = (gi == 0) ? id_rs_used  : id_rt_used;
            assign rf_value = (gi == 0) ? rf_rs_value : rf_rt_value;

            // Youngest producer wins; r0 is never forwarded.
            always_comb begin
                value = rf_value;
                src   = FWD_RF;
                if (addr != '0) begin
                    if (tag_hits(exe_tag_q, addr)) begin
                        value = exe_result;
                        src   = FWD_EXE;
                    end else if (tag_hits(mem_tag_q, addr)) begin
                        value = mem_result;
                        src   = FWD_MEM;
                    end else if (tag_hits(wb_tag_q, addr)) begin
                        value = wb_result;
                        src   = FWD_WB;
                    end
                end
            end

            assign exe_load_hit = tag_hits(exe_tag_q, addr) && exe_tag_q.is_load;
            // With late load data a load still in MEM has nothing to forward yet.
            assign mem_load_hit = (LOAD_LAT == 2) && tag_hits(mem_tag_q, addr) && mem_tag_q.is_load;
            assign hazard       = used && (addr != '0) && (exe_load_hit || mem_load_hit);
        end
    endgenerate

    assign rs_value   = g_op[0].value;
    assign rt_value   = g_op[1].value;
    assign fwd_rs_src = g_op[0].src;
    assign fwd_rt_src = g_op[1].src;
    assign stall      = (g_op[0].hazard | g_op[1].hazard) & ~id_flush;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Only stall cycles that actually cost a pipeline slot are counted.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && !pipe_hold && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_operand_bypass.sv
module tb_id_operand_bypass;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LAT = 1;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pipe_hold = 1'b0;
    logic          id_flush = 1'b0;
    logic [AW-1:0] id_rs_addr = '0;
    logic [AW-1:0] id_rt_addr = '0;
    logic          id_rs_used = 1'b0;
    logic          id_rt_used = 1'b0;
    logic          id_wen = 1'b0;
    logic [AW-1:0] id_waddr = '0;
    logic          id_is_load = 1'b0;
    logic [DW-1:0] rf_rs_value = '0;
    logic [DW-1:0] rf_rt_value = '0;
    logic [DW-1:0] exe_result = '0;
    logic [DW-1:0] mem_result = '0;
    logic [DW-1:0] wb_result = '0;
    logic [DW-1:0] rs_value;
    logic [DW-1:0] rt_value;
    logic [1:0]    fwd_rs_src;
    logic [1:0]    fwd_rt_src;
    logic          stall;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    id_operand_bypass #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .LOAD_LAT (LAT),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_hold   (pipe_hold),
        .id_flush    (id_flush),
        .id_rs_addr  (id_rs_addr),
        .id_rt_addr  (id_rt_addr),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .id_wen      (id_wen),
        .id_waddr    (id_waddr),
        .id_is_load  (id_is_load),
        .rf_rs_value (rf_rs_value),
        .rf_rt_value (rf_rt_value),
        .exe_result  (exe_result),
        .mem_result  (mem_result),
        .wb_result   (wb_result),
        .rs_value    (rs_value),
        .rt_value    (rt_value),
        .fwd_rs_src  (fwd_rs_src),
        .fwd_rt_src  (fwd_rt_src),
        .stall       (stall),
        .stall_count (stall_count)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic wen, input logic [4:0] wa, input logic ld,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic rsu, input logic rtu, input logic fl);
        id_wen = wen; id_waddr = wa; id_is_load = ld;
        id_rs_addr = rs; id_rt_addr = rt;
        id_rs_used = rsu; id_rt_used = rtu; id_flush = fl;
    endtask

    task automatic do_reset();
        pipe_hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- table vectors ----------------
    typedef struct packed { logic wen; logic [4:0] a; logic ld; } ttag_t;

    typedef struct {
        string       name;
        ttag_t       exe_t, mem_t, wb_t;
        logic [4:0]  rs, rt;
        logic        rsu, rtu, fl;
        logic [31:0] rfrs, rfrt, exv, mev, wbv;
        logic [31:0] e_rs, e_rt;
        logic [1:0]  e_rss, e_rts;
        logic        e_stall;
    } vec_t;

    function automatic ttag_t T(input logic w, input logic [4:0] a, input logic l);
        ttag_t t;
        t.wen = w; t.a = a; t.ld = l;
        return t;
    endfunction

    function automatic vec_t mk(input string nm, input ttag_t e, input ttag_t m, input ttag_t w,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic rsu, input logic rtu, input logic fl,
                                input logic [31:0] rfrs, input logic [31:0] rfrt,
                                input logic [31:0] exv, input logic [31:0] mev, input logic [31:0] wbv,
                                input logic [31:0] ers, input logic [31:0] ert,
                                input logic [1:0] erss, input logic [1:0] erts, input logic est);
        vec_t v;
        v.name = nm; v.exe_t = e; v.mem_t = m; v.wb_t = w;
        v.rs = rs; v.rt = rt; v.rsu = rsu; v.rtu = rtu; v.fl = fl;
        v.rfrs = rfrs; v.rfrt = rfrt; v.exv = exv; v.mev = mev; v.wbv = wbv;
        v.e_rs = ers; v.e_rt = ert; v.e_rss = erss; v.e_rts = erts; v.e_stall = est;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // In-flight destinations, index 0 = youngest (EXE), 2 = oldest (WB).
    logic       m_v[3];
    logic [4:0] m_a[3];
    logic       m_l[3];
    int         m_cnt;

    function automatic void ref_operand(input logic [4:0] a, input logic u, input logic [31:0] rf,
                                        output logic [31:0] val, output logic [1:0] src,
                                        output logic haz);
        logic [31:0] res[3];
        res[0] = exe_result; res[1] = mem_result; res[2] = wb_result;
        val = rf; src = 2'd0; haz = 1'b0;
        if (a != 5'd0) begin
            // Scan oldest to youngest so the youngest producer ends up selected.
            for (int k = 2; k >= 0; k--) begin
                if (m_v[k] && m_a[k] == a) begin
                    val = res[k];
                    src = 2'(k + 1);
                end
            end
            for (int k = 0; k < LAT; k++) begin
                if (u && m_v[k] && m_a[k] == a && m_l[k]) haz = 1'b1;
            end
        end
    endfunction

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e_rs, e_rt;
        logic [1:0]  e_rss, e_rts;
        logic        h0, h1, e_stall, stalled;

        // ---------------- reset state ----------------
        rf_rs_value = 32'h55; rf_rt_value = 32'h66;
        exe_result = 32'h77; mem_result = 32'h88; wb_result = 32'h99;
        set_id(1, 3, 1, 3, 4, 1, 1, 0);
        #2 rst_n = 1'b0;
        #2;
        chk("reset.rs_value", rs_value, 32'h55);
        chk("reset.rt_value", rt_value, 32'h66);
        chk("reset.rs_src", 32'(fwd_rs_src), 32'd0);
        chk("reset.rt_src", 32'(fwd_rt_src), 32'd0);
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.count", 32'(stall_count), 32'd0);
        $display("txn reset: rs=%h rt=%h stall=%0d cnt=%0d", rs_value, rt_value, stall, stall_count);
        #4 rst_n = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // ---------------- table-driven vectors ----------------
        vecs[0]  = mk("exe_fwd",   T(1,8,0), T(0,0,0), T(0,0,0), 8, 3, 1, 1, 0,
                      32'h111, 32'h222, 32'h1234, 32'hBBBB, 32'hCCCC, 32'h1234, 32'h222, 2'd1, 2'd0, 0);
        vecs[1]  = mk("exe_prio",  T(1,9,0), T(1,9,0), T(0,0,0), 9, 9, 1, 1, 0,
                      32'h111, 32'h222, 32'hA, 32'hB, 32'hCCCC, 32'hA, 32'hA, 2'd1, 2'd1, 0);
        vecs[2]  = mk("mem_fwd",   T(1,4,0), T(1,9,0), T(1,9,0), 9, 4, 1, 1, 0,
                      32'h111, 32'h222, 32'h1234, 32'hBBBB, 32'hCCCC, 32'hBBBB, 32'h1234, 2'd2, 2'd1, 0);
        vecs[3]  = mk("wb_fwd",    T(0,0,0), T(0,0,0), T(1,7,0), 7, 6, 1, 1, 0,
                      32'h111, 32'h222, 32'h1234, 32'hBBBB, 32'hCCCC, 32'hCCCC, 32'h222, 2'd3, 2'd0, 0);
        vecs[4]  = mk("r0_tags",   T(1,0,1), T(1,0,1), T(1,0,0), 0, 0, 1, 1, 0,
                      32'h0, 32'h0, 32'h1234, 32'hBBBB, 32'hCCCC, 32'h0, 32'h0, 2'd0, 2'd0, 0);
        vecs[5]  = mk("wen0",      T(0,5,0), T(0,5,0), T(0,0,0), 5, 5, 1, 1, 0,
                      32'h111, 32'h222, 32'h1234, 32'hBBBB, 32'hCCCC, 32'h111, 32'h222, 2'd0, 2'd0, 0);
        vecs[6]  = mk("ld_unused", T(1,5,1), T(0,0,0), T(0,0,0), 5, 2, 0, 1, 0,
                      32'h111, 32'h222, 32'h1234, 32'hBBBB, 32'hCCCC, 32'h1234, 32'h222, 2'd1, 2'd0, 0);
        vecs[7]  = mk("ld_use_rt", T(1,5,1), T(0,0,0), T(0,0,0), 2, 5, 1, 1, 0,
                      32'h111, 32'h222, 32'h1234, 32'hBBBB, 32'hCCCC, 32'h0, 32'h0, 2'd0, 2'd0, 1);
        vecs[8]  = mk("ld_flush",  T(1,5,1), T(0,0,0), T(0,0,0), 2, 5, 1, 1, 1,
                      32'h111, 32'h222, 32'h1234, 32'hBBBB, 32'hCCCC, 32'h111, 32'h1234, 2'd0, 2'd1, 0);
        vecs[9]  = mk("ld_in_mem", T(0,0,0), T(1,5,1), T(0,0,0), 5, 1, 1, 1, 0,
                      32'h111, 32'h222, 32'h1234, 32'hBBBB, 32'hCCCC, 32'hBBBB, 32'h222, 2'd2, 2'd0, 0);
        vecs[10] = mk("mem_vs_wb", T(0,0,0), T(1,3,0), T(1,3,0), 3, 3, 1, 1, 0,
                      32'h111, 32'h222, 32'h1234, 32'hBBBB, 32'hCCCC, 32'hBBBB, 32'hBBBB, 2'd2, 2'd2, 0);
        vecs[11] = mk("ld_use_rs", T(1,6,1), T(1,6,0), T(0,0,0), 6, 0, 1, 0, 0,
                      32'h111, 32'h222, 32'h1234, 32'hBBBB, 32'hCCCC, 32'h0, 32'h0, 2'd0, 2'd0, 1);

        for (int i = 0; i < 12; i++) begin
            // Shift the three tags in, oldest first, with no operand in use.
            set_id(vecs[i].wb_t.wen,  vecs[i].wb_t.a,  vecs[i].wb_t.ld,  0, 0, 0, 0, 0); tick();
            set_id(vecs[i].mem_t.wen, vecs[i].mem_t.a, vecs[i].mem_t.ld, 0, 0, 0, 0, 0); tick();
            set_id(vecs[i].exe_t.wen, vecs[i].exe_t.a, vecs[i].exe_t.ld, 0, 0, 0, 0, 0); tick();
            set_id(0, 0, 0, vecs[i].rs, vecs[i].rt, vecs[i].rsu, vecs[i].rtu, vecs[i].fl);
            rf_rs_value = vecs[i].rfrs; rf_rt_value = vecs[i].rfrt;
            exe_result = vecs[i].exv; mem_result = vecs[i].mev; wb_result = vecs[i].wbv;
            @(negedge clk);
            chk({vecs[i].name, ".stall"}, 32'(stall), 32'(vecs[i].e_stall));
            if (!vecs[i].e_stall) begin
                chk({vecs[i].name, ".rs_value"}, rs_value, vecs[i].e_rs);
                chk({vecs[i].name, ".rt_value"}, rt_value, vecs[i].e_rt);
                chk({vecs[i].name, ".rs_src"}, 32'(fwd_rs_src), 32'(vecs[i].e_rss));
                chk({vecs[i].name, ".rt_src"}, 32'(fwd_rt_src), 32'(vecs[i].e_rts));
            end
            $display("txn %s: rs=%h/%0d rt=%h/%0d stall=%0d", vecs[i].name,
                     rs_value, fwd_rs_src, rt_value, fwd_rt_src, stall);
            set_id(0, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("table.count", 32'(stall_count), 32'd0);

        // ---------------- load-use: one stall cycle, then MEM forward ----------------
        do_reset();
        mem_result = 32'hD00D;
        set_id(1, 5, 1, 0, 0, 0, 0, 0); tick();
        set_id(1, 6, 0, 0, 5, 0, 1, 0);
        @(negedge clk);
        chk("lu.stall1", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("lu.stall2", 32'(stall), 32'd0);
        chk("lu.rt_value", rt_value, 32'hD00D);
        chk("lu.rt_src", 32'(fwd_rt_src), 32'd2);
        chk("lu.count", 32'(stall_count), 32'd1);
        $display("txn load_use: rt=%h src=%0d cnt=%0d", rt_value, fwd_rt_src, stall_count);

        // ---------------- load-use squashed by flush ----------------
        do_reset();
        set_id(1, 5, 1, 0, 0, 0, 0, 0); tick();
        set_id(1, 6, 0, 0, 5, 0, 1, 1);
        @(negedge clk);
        chk("flush.stall", 32'(stall), 32'd0);
        tick();
        set_id(0, 0, 0, 6, 0, 1, 0, 0);
        @(negedge clk);
        chk("flush.exe_invalid_src", 32'(fwd_rs_src), 32'd0);
        chk("flush.count", 32'(stall_count), 32'd0);
        $display("txn flush: stall=%0d rs_src=%0d", stall, fwd_rs_src);

        // ---------------- hazard under pipe_hold ----------------
        do_reset();
        mem_result = 32'hBEEF;
        set_id(1, 5, 1, 0, 0, 0, 0, 0); tick();
        set_id(1, 6, 0, 0, 5, 0, 1, 0);
        pipe_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold.stall", 32'(stall), 32'd1);
            chk("hold.count", 32'(stall_count), 32'd0);
            tick();
        end
        pipe_hold = 1'b0;
        @(negedge clk);
        chk("hold.release_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("hold.after_stall", 32'(stall), 32'd0);
        chk("hold.after_src", 32'(fwd_rt_src), 32'd2);
        chk("hold.after_value", rt_value, 32'hBEEF);
        chk("hold.after_count", 32'(stall_count), 32'd1);
        $display("txn hold: stall=%0d cnt=%0d", stall, stall_count);

        // ---------------- counter saturation ----------------
        do_reset();
        for (int i = 0; i < CMAX + 3; i++) begin
            set_id(1, 5, 1, 0, 0, 0, 0, 0); tick();
            set_id(0, 0, 0, 0, 5, 0, 1, 0);
            @(negedge clk);
            chk("sat.stall", 32'(stall), 32'd1);
            tick();
            chk("sat.count", 32'(stall_count), (i + 1 < CMAX) ? 32'(i + 1) : 32'(CMAX));
        end
        $display("txn saturate: cnt=%0d", stall_count);

        // ---------------- async reset mid-stall ----------------
        set_id(1, 5, 1, 0, 0, 0, 0, 0); tick();
        set_id(0, 0, 0, 0, 5, 0, 1, 0);
        @(negedge clk);
        chk("rst_mid.stall_before", 32'(stall), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid.stall", 32'(stall), 32'd0);
        chk("rst_mid.count", 32'(stall_count), 32'd0);
        chk("rst_mid.rt_src", 32'(fwd_rt_src), 32'd0);
        $display("txn reset_mid_stall: stall=%0d cnt=%0d", stall, stall_count);
        #1 rst_n = 1'b1;

        // ---------------- randomized against the model ----------------
        do_reset();
        for (int k = 0; k < 3; k++) begin m_v[k] = 1'b0; m_a[k] = '0; m_l[k] = 1'b0; end
        m_cnt = 0;
        stalled = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!stalled) begin
                set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 4)), $urandom_range(0, 2) == 0,
                       5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
            end
            pipe_hold = ($urandom_range(0, 7) == 0);
            rf_rs_value = $urandom; rf_rt_value = $urandom;
            exe_result = $urandom; mem_result = $urandom; wb_result = $urandom;
            @(negedge clk);
            ref_operand(id_rs_addr, id_rs_used, rf_rs_value, e_rs, e_rss, h0);
            ref_operand(id_rt_addr, id_rt_used, rf_rt_value, e_rt, e_rts, h1);
            e_stall = (h0 | h1) & ~id_flush;
            chk("rnd.stall", 32'(stall), 32'(e_stall));
            chk("rnd.count", 32'(stall_count), 32'(m_cnt));
            if (!e_stall) begin
                chk("rnd.rs_value", rs_value, e_rs);
                chk("rnd.rt_value", rt_value, e_rt);
                chk("rnd.rs_src", 32'(fwd_rs_src), 32'(e_rss));
                chk("rnd.rt_src", 32'(fwd_rt_src), 32'(e_rts));
            end
            $display("txn rnd %0d: rs=%0d rt=%0d hold=%0d fl=%0d stall=%0d srcs=%0d/%0d cnt=%0d",
                     c, id_rs_addr, id_rt_addr, pipe_hold, id_flush, stall, fwd_rs_src, fwd_rt_src, stall_count);
            @(posedge clk);
            if (!pipe_hold) begin
                if (e_stall && m_cnt < CMAX) m_cnt++;
                m_v[2] = m_v[1]; m_a[2] = m_a[1]; m_l[2] = m_l[1];
                m_v[1] = m_v[0]; m_a[1] = m_a[0]; m_l[1] = m_l[0];
                m_v[0] = !(e_stall || id_flush) && id_wen && (id_waddr != 5'd0);
                m_a[0] = id_waddr;
                m_l[0] = id_is_load;
            end
            stalled = e_stall;
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
